imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader that writes the instruction memory of the RV64 single-cycle core. It accepts a byte stream with a valid/ready handshake, parses a 2-byte little-endian word-count header, and assembles little-endian 32-bit instruction words. It writes each word through the instruction memory's write port at consecutive word addresses and holds the CPU in reset (`cpu_hold`) until loading completes. It sits between the host byte source and the instruction memory, on the writer side of the memory the fetch path reads.

## Interface
- `DEPTH`, 1024: instruction memory depth in 32-bit words.
- `AW`, `$clog2(DEPTH)` (10): word-address width.

- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high; clears all state.
- `start` in 1: begin a load session; honoured only in IDLE.
- `in_valid` in 1: byte source has `in_data` valid.
- `in_data` in 8: stream byte.
- `in_ready` out 1: loader accepts a byte this cycle. A transfer occurs when `in_valid && in_ready`.
- `imem_we` out 1: instruction memory write enable, one-cycle pulse per word.
- `imem_addr` out AW: word index to write.
- `imem_wdata` out 32: instruction word.
- `cpu_hold` out 1: high while a session is active; the core is held in reset.
- `done` out 1: one-cycle pulse on successful completion.
- `error` out 1: sticky bad-header flag, cleared on the next accepted `start`.
- `words_loaded` out AW+1: number of words written in the current or last session.

## Operation
- **Reset values.** State is IDLE. The following outputs are 0: `in_ready`, `imem_we`, `imem_addr`, `imem_wdata`, `cpu_hold`, `done`, `error`, `words_loaded`. Internal byte index, length and partial word are also 0.
- **States.** IDLE, LEN, DATA, FLUSH.
- **IDLE.**
  - `in_ready`=0.
  - `start` → LEN. On entry: `cpu_hold`=1, `error`=0, `words_loaded`=0, byte index=0.
- **LEN.**
  - `in_ready`=1.
  - First accepted byte → `len[7:0]`; second → `len[15:8]`.
  - After the second byte, `len` is checked with a 17-bit comparison:
    - `len`==0 or `len`>DEPTH → `error`=1, `cpu_hold`=0, go to IDLE. No `done`.
    - Otherwise → DATA, word address=0.
- **DATA.**
  - `in_ready`=1.
  - Byte k of a word (k=0..3) lands in bits [8k+7:8k].
  - When the 4th byte is accepted, the assembled word is registered onto `imem_wdata`/`imem_addr`, and `imem_we`=1 on the next cycle.
  - After that write, `words_loaded` increments and the address increments.
  - When the 4th byte of word `len`-1 is accepted → FLUSH. `in_ready` drops the following cycle.
- **FLUSH.**
  - The final write is issued (`imem_we`=1).
  - Next cycle: `done`=1 for one cycle, `cpu_hold`=0, state IDLE.
- **Handshake.**
  - No byte is consumed when `in_ready`=0.
  - `in_valid` low stalls the session indefinitely with no timeout. Partial words are held.
- **Simultaneous events.**
  - `start` outside IDLE is ignored.
  - `reset` wins over everything.
  - `reset` mid-session discards the partial word and length, returns to IDLE and deasserts `cpu_hold`. Words already written remain in memory.
- **Addressing.** `imem_addr` = word counter[AW-1:0]. No wrap is possible because `len`≤DEPTH.

## Timing
- Header: 2 accepted bytes. Back-to-back transfers take 2 cycles.
- Word: 4 accepted bytes. `imem_we` is asserted exactly 1 cycle after the 4th byte's transfer cycle.
- Streaming throughput: 1 byte/cycle. Writes overlap with assembly of the next word.
- Completion: last byte accepted at cycle N → final `imem_we` at N+1 → `done`=1 and `cpu_hold`=0 at N+2.
- `start` accepted at cycle S → `cpu_hold`=1 and `in_ready`=1 from S+1.
- `done` and `imem_we` are never high in the same cycle.

## Structure
- **Package `imem_loader_pkg`:**
  - `typedef enum logic [1:0] {IDLE, LEN, DATA, FLUSH} loader_state_t`.
  - Constants `LEN_BYTES`=2 and `BYTES_PER_WORD`=4.
- **Sub-module `word_assembler`:**
  - 2-bit byte index.
  - Little-endian shift/insert into a 32-bit word.
  - Emits `word_valid` with the word on the 4th byte.
  - Cleared by `reset` or session start.
- **Top level:** FSM, length register, word counter and registered write port.

## Test plan
- **Single word.** `start`, then bytes 01 00 13 05 A0 00 → one `imem_we` with `imem_addr`=0 and `imem_wdata`=0x00A00513. Then `done` pulse, `words_loaded`=1, `cpu_hold` low.
- **Full depth.** Header 00 04 (1024) plus 4096 bytes streamed every cycle → 1024 writes, addresses 0..1023 in order. Then `done`, `words_loaded`=1024, no `error`.
- **Bad headers.** Header 00 00 → `error`=1, `cpu_hold`=0, no writes. Header 01 04 (1025) → same. A following `start` clears `error`.
- **Backpressure/stall.** Random `in_valid` gaps during a 3-word load → write data and addresses identical to the gap-free run. No byte is consumed while `in_ready`=0.
- **Reset mid-word.** Reset after 2 of 4 bytes of word 1 → all outputs return to 0 next cycle, word 0 was already written, and no write for word 1. A fresh session then loads correctly from address 0.
- **Start ignored.** `start` pulsed during DATA → no effect on state, counters or outputs.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
// The header is a little-endian 16-bit word count; instructions are little-endian 32-bit words.
package imem_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LEN,
        DATA,
        FLUSH
    } loader_state_t;

    localparam int LEN_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/word_assembler.sv
// Packs a little-endian byte stream into 32-bit words. word_valid and word_data are
// combinational in the cycle the 4th byte of a word is presented with byte_valid.
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word_data
);

    logic [1:0]  idx_reg;
    logic [31:0] partial_reg;
    logic [31:0] merged;

    // The incoming byte replaces only the lane selected by the byte index.
    generate
        for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
            assign merged[8*gi +: 8] = (idx_reg == 2'(gi)) ? byte_data : partial_reg[8*gi +: 8];
        end
    endgenerate

    assign word_valid = byte_valid && (idx_reg == 2'(BYTES_PER_WORD - 1));
    assign word_data  = merged;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            idx_reg     <= 2'd0;
            partial_reg <= 32'd0;
        end else if (byte_valid) begin
            partial_reg <= merged;
            idx_reg     <= idx_reg + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a 2-byte word-count header, then streams little-endian words into
// the instruction memory write port while holding the core in reset.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          cpu_hold,
    output logic          done,
    output logic          error,
    output logic [AW:0]   words_loaded
);

    loader_state_t state_reg, state_next;

    logic          hdr_idx_reg;
    logic [15:0]   len_reg;
    logic [AW:0]   word_cnt_reg;
    logic          imem_we_reg;
    logic [AW-1:0] imem_addr_reg;
    logic [31:0]   imem_wdata_reg;
    logic          cpu_hold_reg;
    logic          done_reg;
    logic          error_reg;
    logic [AW:0]   words_loaded_reg;

    logic          xfer;
    logic          session_start;
    logic          hdr_last;
    logic          hdr_bad;
    logic          last_word;
    logic          word_valid;
    logic [31:0]   word_data;
    logic [16:0]   len_hdr;
    logic [16:0]   words_after;

    assign in_ready = (state_reg == LEN) || (state_reg == DATA);
    assign xfer     = in_valid && in_ready;

    // Full length as it will be once the high byte currently on the bus is captured.
    assign len_hdr  = {1'b0, in_data, len_reg[7:0]};
    assign hdr_last = in_valid && (hdr_idx_reg == 1'(LEN_BYTES - 1));
    assign hdr_bad  = (len_hdr == 17'd0) || (len_hdr > 17'(DEPTH));

    assign words_after = 17'(word_cnt_reg) + 17'd1;
    assign last_word   = word_valid && (words_after == {1'b0, len_reg});

    word_assembler u_word_assembler (
        .clk        (clk),
        .reset      (reset),
        .clear      (session_start),
        .byte_valid (in_valid && (state_reg == DATA)),
        .byte_data  (in_data),
        .word_valid (word_valid),
        .word_data  (word_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        session_start = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    session_start = 1'b1;
                    state_next    = LEN;
                end
            end
            LEN: begin
                if (hdr_last) begin
                    state_next = hdr_bad ? IDLE : DATA;
                end
            end
            DATA: begin
                if (last_word) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hdr_idx_reg      <= 1'b0;
            len_reg          <= 16'd0;
            word_cnt_reg     <= '0;
            imem_we_reg      <= 1'b0;
            imem_addr_reg    <= '0;
            imem_wdata_reg   <= 32'd0;
            cpu_hold_reg     <= 1'b0;
            done_reg         <= 1'b0;
            error_reg        <= 1'b0;
            words_loaded_reg <= '0;
        end else begin
            imem_we_reg <= 1'b0;
            done_reg    <= 1'b0;

            if (session_start) begin
                cpu_hold_reg     <= 1'b1;
                error_reg        <= 1'b0;
                words_loaded_reg <= '0;
                hdr_idx_reg      <= 1'b0;
                len_reg          <= 16'd0;
                word_cnt_reg     <= '0;
            end

            if (state_reg == LEN && xfer) begin
                if (hdr_idx_reg == 1'(LEN_BYTES - 1)) begin
                    len_reg[15:8] <= in_data;
                    hdr_idx_reg   <= 1'b0;
                    word_cnt_reg  <= '0;
                    if (hdr_bad) begin
                        error_reg    <= 1'b1;
                        cpu_hold_reg <= 1'b0;
                    end
                end else begin
                    len_reg[7:0] <= in_data;
                    hdr_idx_reg  <= 1'b1;
                end
            end

            // Register the completed word; the write overlaps assembly of the next one.
            if (word_valid) begin
                imem_wdata_reg <= word_data;
                imem_addr_reg  <= word_cnt_reg[AW-1:0];
                imem_we_reg    <= 1'b1;
                word_cnt_reg   <= word_cnt_reg + 1'b1;
            end

            if (imem_we_reg) begin
                words_loaded_reg <= words_loaded_reg + 1'b1;
            end

            if (state_reg == FLUSH) begin
                done_reg     <= 1'b1;
                cpu_hold_reg <= 1'b0;
            end
        end
    end

    assign imem_we      = imem_we_reg;
    assign imem_addr    = imem_addr_reg;
    assign imem_wdata   = imem_wdata_reg;
    assign cpu_hold     = cpu_hold_reg;
    assign done         = done_reg;
    assign error        = error_reg;
    assign words_loaded = words_loaded_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: a byte-stream model predicts every memory write,
// its cycle, and the done pulse; a compare process checks them each cycle.
module tb_imem_loader;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic          clk;
    logic          reset;
    logic          start;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold;
    logic          done;
    logic          error;
    logic [AW:0]   words_loaded;

    imem_loader #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t         exp_q[$];
    logic [7:0]  stream[$];
    int          ncmp = 0;
    int          nfail = 0;
    int          cyc = 0;
    int          exp_done_cyc = -1;
    int          wr_count = 0;
    int          last_addr = 0;
    logic [31:0] last_wdata = 32'd0;
    bit          start_noise = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint expv);
        ncmp++;
        if (act != expv) begin
            nfail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Per-cycle comparison of the write port and done pulse against the model.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                ncmp++;
                nfail++;
                $display("FAIL missed_write: got none, required addr %0d data %08h at cycle %0d", e.addr, e.data, e.cyc);
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                ncmp++;
                if (!imem_we || imem_addr != AW'(e.addr) || imem_wdata != e.data) begin
                    nfail++;
                    $display("FAIL write: got we=%0b addr=%0d data=%08h, required we=1 addr=%0d data=%08h (cycle %0d)",
                             imem_we, imem_addr, imem_wdata, e.addr, e.data, cyc);
                end
            end else if (imem_we) begin
                ncmp++;
                nfail++;
                $display("FAIL unexpected_write: got addr=%0d data=%08h, required no write (cycle %0d)",
                         imem_addr, imem_wdata, cyc);
            end
            if (imem_we) begin
                wr_count++;
                last_addr  = int'(imem_addr);
                last_wdata = imem_wdata;
            end
            check("done_pulse", done, (cyc == exp_done_cyc) ? 1 : 0);
        end
    end

    // Offers one byte until it is accepted; returns the cycle it was accepted in.
    task automatic send_byte(input logic [7:0] b, input int gap_pct, output int acc_cyc);
        int  tries = 0;
        bit  acc = 0;
        acc_cyc = -1;
        while (!acc) begin
            @(negedge clk);
            in_data  = b;
            in_valid = ($urandom_range(99) >= gap_pct);
            start    = start_noise ? ($urandom_range(3) == 0) : 1'b0;
            acc      = in_valid && in_ready;
            if (acc) acc_cyc = cyc;
            tries++;
            if (!acc && tries > 1000) begin
                ncmp++;
                nfail++;
                $display("FAIL byte_accept: got no transfer in %0d cycles, required transfer", tries);
                return;
            end
            @(posedge clk);
        end
    endtask

    task automatic make_stream(input int len_field, input int nwords);
        stream.delete();
        stream.push_back(8'(len_field));
        stream.push_back(8'(len_field >> 8));
        for (int i = 0; i < 4 * nwords; i++) stream.push_back(8'($urandom_range(255)));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, in_ready, 0);
        check({tag, "_we"}, imem_we, 0);
        check({tag, "_addr"}, imem_addr, 0);
        check({tag, "_wdata"}, imem_wdata, 0);
        check({tag, "_hold"}, cpu_hold, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, error, 0);
        check({tag, "_wl"}, words_loaded, 0);
    endtask

    // One load session of the current stream; stop_after >= 0 resets after that many bytes.
    task automatic run_session(input int gap_pct, input bit noise, input int stop_after);
        int  len, nbytes, ac, last_ac;
        bit  bad;
        wr_t e;
        len    = int'(stream[0]) + 256 * int'(stream[1]);
        bad    = (len == 0) || (len > DEPTH);
        nbytes = bad ? 2 : 2 + 4 * len;
        if (stop_after >= 0 && stop_after < nbytes) nbytes = stop_after;

        @(negedge clk);
        start    = 1'b1;
        in_valid = 1'b0;
        check("idle_ready", in_ready, 0);
        @(negedge clk);
        start = 1'b0;
        check("start_ready", in_ready, 1);
        check("start_hold", cpu_hold, 1);
        check("start_err", error, 0);
        check("start_wl", words_loaded, 0);

        start_noise = noise;
        last_ac = 0;
        for (int j = 0; j < nbytes; j++) begin
            send_byte(stream[j], gap_pct, ac);
            last_ac = ac;
            if (j >= 2 && ((j - 2) % 4) == 3) begin
                e.addr = (j - 2) / 4;
                e.data = {stream[j], stream[j-1], stream[j-2], stream[j-3]};
                e.cyc  = ac + 1;
                exp_q.push_back(e);
            end
        end
        start_noise = 0;

        if (stop_after >= 0) begin
            @(negedge clk);
            in_valid = 1'b0;
            start    = 1'b0;
            reset    = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            check_all_zero("midreset");
            check("midreset_pending", exp_q.size(), 0);
        end else if (bad) begin
            @(negedge clk);
            in_valid = 1'b0;
            start    = 1'b0;
            check("bad_err", error, 1);
            check("bad_hold", cpu_hold, 0);
            check("bad_ready", in_ready, 0);
            check("bad_wl", words_loaded, 0);
        end else begin
            exp_done_cyc = last_ac + 2;
            @(negedge clk);
            in_valid = 1'b0;
            start    = 1'b0;
            check("flush_ready", in_ready, 0);
            check("flush_hold", cpu_hold, 1);
            @(negedge clk);
            check("end_hold", cpu_hold, 0);
            check("end_wl", words_loaded, len);
            check("end_err", error, 0);
            check("end_pending", exp_q.size(), 0);
            exp_done_cyc = -1;
        end
    endtask

    initial begin
        int n;
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // Single word: 01 00 13 05 A0 00
        stream.delete();
        stream.push_back(8'h01); stream.push_back(8'h00);
        stream.push_back(8'h13); stream.push_back(8'h05);
        stream.push_back(8'hA0); stream.push_back(8'h00);
        wr_count = 0;
        run_session(0, 0, -1);
        check("lit_wdata", last_wdata, 32'h00A00513);
        check("lit_addr", last_addr, 0);
        check("lit_wl", words_loaded, 1);
        check("lit_count", wr_count, 1);

        // Three words gap-free, then the same stream with random stalls.
        make_stream(3, 3);
        run_session(0, 0, -1);
        run_session(40, 0, -1);

        // Bad headers: zero length and DEPTH+1; the next start clears error.
        make_stream(0, 0);
        run_session(0, 0, -1);
        make_stream(1025, 0);
        run_session(10, 0, -1);

        // Start pulses during the session are ignored.
        make_stream(5, 5);
        run_session(30, 1, -1);

        // Reset after 2 bytes of word 1, then a fresh session from address 0.
        make_stream(3, 3);
        run_session(0, 0, 8);
        make_stream(2, 2);
        run_session(20, 0, -1);
        check("fresh_last_addr", last_addr, 1);

        for (int k = 0; k < 3; k++) begin
            n = $urandom_range(1, 12);
            make_stream(n, n);
            run_session(25, 0, -1);
        end

        // Full depth streamed every cycle.
        wr_count = 0;
        make_stream(1024, 1024);
        run_session(0, 0, -1);
        check("full_count", wr_count, 1024);
        check("full_last_addr", last_addr, 1023);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
